// File: rtl/tx_mii_arbiter.sv
// Two-source MII transmit arbiter: grants the PHY port to A or B, forwards the
// granted nibbles with one cycle of latency, enforces the IFG and aborts bad frames.
module tx_mii_arbiter #(
  parameter int unsigned IFG_NIBBLES = 24,
  parameter int unsigned MAX_NIBBLES = 3052,
  parameter int unsigned START_TO    = 16,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic       phy_txclk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] a_txd,
  input  logic       a_txen,
  input  logic       req_b,
  input  logic [3:0] b_txd,
  input  logic       b_txen,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] phy_txd,
  output logic       phy_txen,
  output logic       phy_txer,
  output logic       frame_done,
  output logic       abort,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XMIT,
    ABORT,
    IFG
  } state_t;

  localparam logic [11:0] IFG_LAST = 12'(IFG_NIBBLES - 1);
  localparam logic [11:0] TO_LAST  = 12'(START_TO - 1);
  localparam logic [11:0] MAX_CNT  = 12'(MAX_NIBBLES);

  state_t      state_q, state_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        txer_q, txer_d;
  logic        frame_done_q, frame_done_d;
  logic        abort_q, abort_d;

  logic        win_b;
  logic        src_txen;
  logic [3:0]  src_txd;

  // Only the granted source is ever looked at; the other one is ignored.
  assign src_txen = gnt_b_q ? b_txen : a_txen;
  assign src_txd  = gnt_b_q ? b_txd  : a_txd;

  always_comb begin
    win_b = 1'b0;
    if (req_a && req_b) begin
      win_b = FIXED_PRIO ? 1'b0 : !last_b_q;
    end else begin
      win_b = req_b;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_a_d      = gnt_a_q;
    gnt_b_d      = gnt_b_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    txd_d        = txd_q;
    txen_d       = txen_q;
    txer_d       = txer_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          gnt_a_d  = !win_b;
          gnt_b_d  = win_b;
          last_b_d = win_b;
          cnt_d    = 12'd0;
          state_d  = GRANT;
        end
      end

      GRANT: begin
        if (src_txen) begin
          txen_d  = 1'b1;
          txd_d   = src_txd;
          cnt_d   = 12'd1;
          state_d = XMIT;
        end else if (cnt_q == TO_LAST) begin
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          abort_d = 1'b1;
          cnt_d   = 12'd0;
          state_d = IFG;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      XMIT: begin
        if (!src_txen) begin
          txen_d       = 1'b0;
          txd_d        = 4'd0;
          gnt_a_d      = 1'b0;
          gnt_b_d      = 1'b0;
          frame_done_d = 1'b1;
          cnt_d        = 12'd0;
          state_d      = IFG;
        end else if (cnt_q == MAX_CNT) begin
          // Oversize: spend one more cycle signalling the error to the PHY.
          txer_d  = 1'b1;
          txd_d   = 4'd0;
          state_d = ABORT;
        end else begin
          txd_d = src_txd;
          cnt_d = cnt_q + 12'd1;
        end
      end

      ABORT: begin
        txen_d  = 1'b0;
        txer_d  = 1'b0;
        txd_d   = 4'd0;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        abort_d = 1'b1;
        cnt_d   = 12'd0;
        state_d = IFG;
      end

      IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 12'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge phy_txclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      last_b_q     <= 1'b1;
      cnt_q        <= 12'd0;
      txd_q        <= 4'd0;
      txen_q       <= 1'b0;
      txer_q       <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      last_b_q     <= last_b_d;
      cnt_q        <= cnt_d;
      txd_q        <= txd_d;
      txen_q       <= txen_d;
      txer_q       <= txer_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign phy_txd    = txd_q;
  assign phy_txen   = txen_q;
  assign phy_txer   = txer_q;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tx_mii_arbiter.sv
// Scoreboard bench for tx_mii_arbiter: three instances (round-robin, fixed priority,
// small MAX_NIBBLES) share stimulus; a monitor checks the selected one against queues.
module tb_tx_mii_arbiter;

  localparam int IFG_N     = 24;
  localparam int BIG_MAX   = 3052;
  localparam int SMALL_MAX = 64;
  localparam int MIN_GAP   = IFG_N + 2;
  localparam int EV_DONE   = 1;
  localparam int EV_ABORT  = 2;

  typedef struct {
    logic [4:0] val;
    int         cyc;
  } nib_t;

  logic       phy_txclk;
  logic       reset;
  logic       req_a, req_b, a_txen, b_txen;
  logic [3:0] a_txd, b_txd;

  logic       o_gnt_a [3];
  logic       o_gnt_b [3];
  logic [3:0] o_txd   [3];
  logic       o_txen  [3];
  logic       o_txer  [3];
  logic       o_fd    [3];
  logic       o_abort [3];
  logic       o_busy  [3];

  logic       m_gnt_a, m_gnt_b, m_txen, m_txer, m_fd, m_abort, m_busy;
  logic [3:0] m_txd;

  int   sel;
  int   cur_max;
  int   cyc;
  int   mon_run;
  int   num_checks;
  int   num_errors;
  int   a_frames, b_frames, a_len, b_len;

  nib_t exp_nib[$];
  int   exp_len[$];
  int   exp_evt[$];
  int   exp_gnt[$];

  tx_mii_arbiter #(.IFG_NIBBLES(IFG_N), .MAX_NIBBLES(BIG_MAX), .START_TO(16), .FIXED_PRIO(1'b0)) dut_rr (
    .phy_txclk(phy_txclk), .reset(reset),
    .req_a(req_a), .a_txd(a_txd), .a_txen(a_txen),
    .req_b(req_b), .b_txd(b_txd), .b_txen(b_txen),
    .gnt_a(o_gnt_a[0]), .gnt_b(o_gnt_b[0]), .phy_txd(o_txd[0]), .phy_txen(o_txen[0]),
    .phy_txer(o_txer[0]), .frame_done(o_fd[0]), .abort(o_abort[0]), .busy(o_busy[0])
  );

  tx_mii_arbiter #(.IFG_NIBBLES(IFG_N), .MAX_NIBBLES(BIG_MAX), .START_TO(16), .FIXED_PRIO(1'b1)) dut_fp (
    .phy_txclk(phy_txclk), .reset(reset),
    .req_a(req_a), .a_txd(a_txd), .a_txen(a_txen),
    .req_b(req_b), .b_txd(b_txd), .b_txen(b_txen),
    .gnt_a(o_gnt_a[1]), .gnt_b(o_gnt_b[1]), .phy_txd(o_txd[1]), .phy_txen(o_txen[1]),
    .phy_txer(o_txer[1]), .frame_done(o_fd[1]), .abort(o_abort[1]), .busy(o_busy[1])
  );

  tx_mii_arbiter #(.IFG_NIBBLES(IFG_N), .MAX_NIBBLES(SMALL_MAX), .START_TO(16), .FIXED_PRIO(1'b0)) dut_sm (
    .phy_txclk(phy_txclk), .reset(reset),
    .req_a(req_a), .a_txd(a_txd), .a_txen(a_txen),
    .req_b(req_b), .b_txd(b_txd), .b_txen(b_txen),
    .gnt_a(o_gnt_a[2]), .gnt_b(o_gnt_b[2]), .phy_txd(o_txd[2]), .phy_txen(o_txen[2]),
    .phy_txer(o_txer[2]), .frame_done(o_fd[2]), .abort(o_abort[2]), .busy(o_busy[2])
  );

  // Route the instance under test to the monitor and the source models.
  always_comb begin
    m_gnt_a = o_gnt_a[sel];
    m_gnt_b = o_gnt_b[sel];
    m_txd   = o_txd[sel];
    m_txen  = o_txen[sel];
    m_txer  = o_txer[sel];
    m_fd    = o_fd[sel];
    m_abort = o_abort[sel];
    m_busy  = o_busy[sel];
  end

  initial begin
    phy_txclk = 1'b0;
    forever #5 phy_txclk = ~phy_txclk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual != expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [3:0] nib(input int src, input int i);
    if (i < 15) return 4'h5;
    if (i == 15) return 4'hD;
    return 4'((i + 3 * src) & 15);
  endfunction

  task automatic applyStimulus(input logic ra, input logic rb);
    @(posedge phy_txclk);
    #1;
    req_a = ra;
    req_b = rb;
  endtask

  // Source model: drives n nibbles and records what the PHY side must show.
  task automatic sendFrame(input int src, input int n);
    nib_t t;
    int   mx;
    mx = cur_max;
    exp_len.push_back((n > mx) ? mx + 1 : n);
    exp_evt.push_back((n > mx) ? EV_ABORT : EV_DONE);
    for (int i = 0; i < n; i++) begin
      if (reset) break;
      if (src == 0) begin
        a_txen = 1'b1;
        a_txd  = nib(0, i);
      end else begin
        b_txen = 1'b1;
        b_txd  = nib(1, i);
      end
      t.cyc = cyc;
      if (i < mx) begin
        t.val = {1'b0, nib(src, i)};
        exp_nib.push_back(t);
      end else if (i == mx) begin
        t.val = 5'h10;
        exp_nib.push_back(t);
      end
      @(posedge phy_txclk);
      #1;
    end
    if (src == 0) begin
      a_txen = 1'b0;
      a_txd  = 4'h0;
    end else begin
      b_txen = 1'b0;
      b_txd  = 4'h0;
    end
  endtask

  initial begin
    forever begin
      @(posedge phy_txclk);
      #1;
      if (m_gnt_a && a_frames > 0 && !reset) begin
        a_frames--;
        sendFrame(0, a_len);
      end
    end
  end

  initial begin
    forever begin
      @(posedge phy_txclk);
      #1;
      if (m_gnt_b && b_frames > 0 && !reset) begin
        b_frames--;
        sendFrame(1, b_len);
      end
    end
  end

  task automatic flushQueues();
    exp_nib.delete();
    exp_len.delete();
    exp_evt.delete();
    exp_gnt.delete();
  endtask

  task automatic applyReset();
    @(posedge phy_txclk);
    #3;
    reset = 1'b1;
    flushQueues();
    repeat (2) @(posedge phy_txclk);
    #3;
    reset = 1'b0;
  endtask

  task automatic waitFramesStarted(input int src);
    for (int n = 0; n < 5000 && ((src == 0) ? a_frames : b_frames) != 0; n++) begin
      @(posedge phy_txclk);
      #1;
    end
    checkOutput((src == 0) ? "a_frames_started" : "b_frames_started",
                (src == 0) ? a_frames : b_frames, 0);
  endtask

  task automatic waitDrain();
    int pending;
    pending = exp_nib.size() + exp_len.size() + exp_evt.size() + exp_gnt.size();
    for (int n = 0; n < 5000 && pending != 0; n++) begin
      @(posedge phy_txclk);
      #1;
      pending = exp_nib.size() + exp_len.size() + exp_evt.size() + exp_gnt.size();
    end
    checkOutput("scoreboard_drained", pending, 0);
    repeat (40) @(posedge phy_txclk);
    #1;
    checkOutput("busy_after_ifg", int'(m_busy), 0);
  endtask

  // Monitor: samples mid-cycle (rising edge) and pops expectations as outputs appear.
  initial begin
    logic prev_txen, prev_ga, prev_gb;
    int   low_run, v;
    bit   seen_fall;
    nib_t e;
    prev_txen = 1'b0;
    prev_ga   = 1'b0;
    prev_gb   = 1'b0;
    low_run   = 0;
    seen_fall = 1'b0;
    forever begin
      @(posedge phy_txclk);
      cyc++;
      if (reset) begin
        prev_txen = 1'b0;
        prev_ga   = 1'b0;
        prev_gb   = 1'b0;
        mon_run   = 0;
        low_run   = 0;
        seen_fall = 1'b0;
        continue;
      end
      checkOutput("gnt_exclusive", int'(m_gnt_a & m_gnt_b), 0);
      if ((m_gnt_a && !prev_ga) || (m_gnt_b && !prev_gb)) begin
        if (exp_gnt.size() == 0) checkOutput("unexpected_grant", int'(m_gnt_b), -1);
        else checkOutput("grant_owner", int'(m_gnt_b), exp_gnt.pop_front());
      end
      if (m_txen) begin
        if (!prev_txen && seen_fall)
          checkOutput("ifg_gap", (low_run < MIN_GAP) ? low_run : MIN_GAP, MIN_GAP);
        low_run = 0;
        mon_run++;
        if (exp_nib.size() == 0) begin
          checkOutput("unexpected_nibble", int'({m_txer, m_txd}), -1);
        end else begin
          e = exp_nib.pop_front();
          checkOutput("phy_txer_txd", int'({m_txer, m_txd}), int'(e.val));
          checkOutput("data_latency", cyc - e.cyc, 1);
        end
      end else begin
        checkOutput("idle_txer_txd", int'({m_txer, m_txd}), 0);
        if (prev_txen) begin
          seen_fall = 1'b1;
          checkOutput("end_pulse_at_txen_fall", int'(m_fd | m_abort), 1);
          if (exp_len.size() == 0) checkOutput("unexpected_frame_end", mon_run, -1);
          else checkOutput("txen_high_cycles", mon_run, exp_len.pop_front());
          mon_run = 0;
          low_run = 0;
        end
        low_run++;
      end
      if (m_fd || m_abort) begin
        v = (m_fd && m_abort) ? 3 : (m_abort ? EV_ABORT : EV_DONE);
        if (exp_evt.size() == 0) checkOutput("unexpected_end_event", v, -1);
        else checkOutput("end_event", v, exp_evt.pop_front());
      end
      prev_txen = m_txen;
      prev_ga   = m_gnt_a;
      prev_gb   = m_gnt_b;
    end
  end

  initial begin
    int hi;
    num_checks = 0;
    num_errors = 0;
    cyc        = 0;
    mon_run    = 0;
    sel        = 0;
    cur_max    = BIG_MAX;
    reset      = 1'b1;
    req_a      = 1'b0;
    req_b      = 1'b0;
    a_txen     = 1'b0;
    b_txen     = 1'b0;
    a_txd      = 4'h0;
    b_txd      = 4'h0;
    a_frames   = 0;
    b_frames   = 0;
    a_len      = 0;
    b_len      = 0;

    repeat (3) @(posedge phy_txclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      checkOutput("reset_outputs",
                  int'({m_gnt_a, m_gnt_b, m_txd, m_txen, m_txer, m_fd, m_abort, m_busy}), 0);
    end
    sel = 0;
    @(posedge phy_txclk);
    #3;
    reset = 1'b0;

    $display("[TB] A-only 100-nibble frame");
    exp_gnt.push_back(0);
    a_len    = 100;
    a_frames = 1;
    applyStimulus(1'b1, 1'b0);
    @(negedge phy_txclk);
    #1;
    checkOutput("gnt_a_one_edge_after_req", int'(m_gnt_a), 1);
    req_a = 1'b0;
    waitDrain();

    $display("[TB] round-robin alternation");
    applyReset();
    sel = 0;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    a_len    = 40;
    b_len    = 40;
    a_frames = 2;
    b_frames = 2;
    applyStimulus(1'b1, 1'b1);
    waitFramesStarted(1);
    req_a = 1'b0;
    req_b = 1'b0;
    waitDrain();

    $display("[TB] fixed priority");
    applyReset();
    sel = 1;
    exp_gnt.push_back(0);
    exp_gnt.push_back(0);
    exp_gnt.push_back(0);
    a_len    = 40;
    a_frames = 3;
    b_frames = 0;
    applyStimulus(1'b1, 1'b1);
    waitFramesStarted(0);
    req_a = 1'b0;
    req_b = 1'b0;
    waitDrain();

    $display("[TB] B pending during IFG");
    applyReset();
    sel = 0;
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    a_len    = 20;
    b_len    = 20;
    a_frames = 1;
    b_frames = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (10) @(posedge phy_txclk);
    #1;
    req_a = 1'b0;
    req_b = 1'b1;
    waitFramesStarted(1);
    req_b = 1'b0;
    waitDrain();

    $display("[TB] start timeout");
    applyReset();
    sel = 0;
    exp_gnt.push_back(0);
    exp_evt.push_back(EV_ABORT);
    a_frames = 0;
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 20 && !m_gnt_a; n++) begin
      @(posedge phy_txclk);
      #1;
    end
    req_a = 1'b0;
    hi = 0;
    while (m_gnt_a && hi < 100) begin
      @(posedge phy_txclk);
      #1;
      hi++;
    end
    checkOutput("timeout_grant_cycles", hi, 16);
    waitDrain();

    $display("[TB] oversize abort with MAX_NIBBLES=64");
    applyReset();
    sel      = 2;
    cur_max  = SMALL_MAX;
    exp_gnt.push_back(1);
    b_len    = 100;
    b_frames = 1;
    applyStimulus(1'b0, 1'b1);
    waitFramesStarted(1);
    req_b = 1'b0;
    waitDrain();
    repeat (40) @(posedge phy_txclk);

    $display("[TB] asynchronous reset mid-frame");
    applyReset();
    sel      = 0;
    cur_max  = BIG_MAX;
    exp_gnt.push_back(0);
    a_len    = 60;
    a_frames = 1;
    applyStimulus(1'b1, 1'b0);
    waitFramesStarted(0);
    req_a = 1'b0;
    for (int n = 0; n < 200 && mon_run < 30; n++) begin
      @(posedge phy_txclk);
      #1;
    end
    checkOutput("reached_nibble_30", (mon_run >= 30) ? 30 : mon_run, 30);
    #2;
    reset = 1'b1;
    flushQueues();
    #1;
    checkOutput("async_reset_txen", int'(m_txen), 0);
    checkOutput("async_reset_gnt_a", int'(m_gnt_a), 0);
    checkOutput("async_reset_busy", int'(m_busy), 0);
    checkOutput("async_reset_txer", int'(m_txer), 0);
    repeat (2) @(posedge phy_txclk);
    #3;
    reset = 1'b0;
    exp_gnt.push_back(1);
    b_len    = 10;
    b_frames = 1;
    applyStimulus(1'b0, 1'b1);
    waitFramesStarted(1);
    req_b = 1'b0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/tx_mii_arbiter.md
# tx_mii_arbiter

Shares one MII transmit port between two frame sources: A, the data-frame transmitter, and B, the control/"need-data" frame generator. It grants the port to one source at a time and forwards that source's nibbles to the PHY with one clock of latency. It enforces the IEEE 802.3 inter-frame gap and aborts oversized or stalled transmissions. It sits between the frame builders and the PHY pins `phy_txd`, `phy_txen` and `phy_txer`.

## Interface
Parameters:
- `IFG_NIBBLES`, 24: minimum number of `phy_txen`-low cycles after a frame (96 bit times).
- `MAX_NIBBLES`, 3052: maximum number of nibbles forwarded per grant, preamble included. Range 1..4095.
- `START_TO`, 16: cycles a granted source may take to raise its `txen` before the grant is withdrawn.
- `FIXED_PRIO`, 0: 0 selects round-robin arbitration; 1 gives A absolute priority.

Ports:
- `phy_txclk`  in  1  MII transmit clock. All state updates on its falling edge.
- `reset`  in  1  asynchronous, active-high.
- `req_a`  in  1  source A requests the port.
- `a_txd`  in  4  source A nibble.
- `a_txen`  in  1  source A frame enable.
- `req_b`  in  1  source B requests the port.
- `b_txd`  in  4  source B nibble.
- `b_txen`  in  1  source B frame enable.
- `gnt_a`  out  1  grant to A.
- `gnt_b`  out  1  grant to B.
- `phy_txd`  out  4  nibble to the PHY.
- `phy_txen`  out  1  transmit enable to the PHY.
- `phy_txer`  out  1  transmit error to the PHY.
- `frame_done`  out  1  one-cycle pulse when a frame ends normally.
- `abort`  out  1  one-cycle pulse on an oversize abort or a start timeout.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The arbiter has five states: IDLE, GRANT, XMIT, ABORT, IFG.
- IDLE: if any request is sampled, select a winner, raise its `gnt_*` and go to GRANT.
  - With both requests and `FIXED_PRIO=0`, the winner is the source not served last.
  - With `FIXED_PRIO=1`, A wins.
  - A single request always wins.
- `last` pointer: updated when a grant is issued. Resets to B, so A wins the first tie.
- GRANT: the timeout counter counts cycles.
  - If the granted `*_txen` is sampled at 1: `phy_txen<=1`, `phy_txd<=*_txd`, nibble count `<=1`, go to XMIT.
  - If the timeout counter reaches `START_TO` without that: drop the grant, pulse `abort`, go to IFG.
- XMIT: each cycle `phy_txd<=*_txd` from the granted source and the nibble count increments.
  - Granted `*_txen` sampled at 0: `phy_txen<=0`, `phy_txd<=0`, drop the grant, pulse `frame_done`, go to IFG.
  - Count equals `MAX_NIBBLES` while `*_txen` is still 1: go to ABORT.
- ABORT: hold for one cycle with `phy_txen=1`, `phy_txer=1`, `phy_txd=0`. Then `phy_txen<=0`, `phy_txer<=0`, drop the grant, pulse `abort`, go to IFG.
- IFG: count `IFG_NIBBLES` cycles with `phy_txen` low, then go to IDLE.
- Ungranted source inputs are ignored at all times.
- Changes to `req_*` after the grant is issued are ignored. Frame length is governed only by the granted `*_txen`.
- Counters are 12 bits wide and never wrap inside a grant.

## Timing
- Reset values: `phy_txd=0`, `phy_txen=0`, `phy_txer=0`, `gnt_a=0`, `gnt_b=0`, `frame_done=0`, `abort=0`, `busy=0`, state IDLE.
- Reset is asynchronous: an assertion mid-frame drops `phy_txen` immediately, with no `phy_txer`.
- Request to grant: `gnt_*` rises at the first falling edge that samples `req_*` high while in IDLE.
- Data latency: exactly one `phy_txclk` cycle. A nibble sampled at edge k appears on `phy_txd` after edge k.
- `phy_txen` high duration equals the source `txen` high duration, capped at `MAX_NIBBLES`+1 (abort cycle included).
- Gap between the fall of `phy_txen` and the next rise is at least `IFG_NIBBLES`+2 cycles (IFG, then IDLE, then GRANT).
- A request arriving during IFG is held pending and served from IDLE.
- `frame_done` and `abort` are asserted for one cycle, on the edge that enters IFG.
- `busy` mirrors the state register.
- Never are both `gnt_a` and `gnt_b` high together.

## Test plan
- A-only frame of 100 nibbles (0x5 preamble, then a counting pattern): `gnt_a` rises one edge after `req_a`; `phy_txd` matches `a_txd` delayed by one cycle; `phy_txen` is high for exactly 100 cycles; one `frame_done` pulse; `phy_txer` stays 0.
- `req_a` and `req_b` held together, `FIXED_PRIO=0`, each source sending 40-nibble frames: grants alternate A, B, A, B. With `FIXED_PRIO=1`: A, A, A, and B is never granted.
- Back-to-back frames with the B request pending during IFG: `phy_txen` is low for at least 26 cycles between frames.
- A granted, `a_txen` held 0: after 16 cycles `gnt_a` falls, `abort` pulses, and `phy_txen` never rises.
- `MAX_NIBBLES=64`, B sends 100 nibbles: `phy_txen` is high for 65 cycles; the last cycle has `phy_txer=1`, `phy_txd=0`; `abort` pulses; `frame_done` does not pulse.
- `reset` asserted at nibble 30 of an A frame: `phy_txen`, `gnt_a` and `busy` go to 0 asynchronously. After release, a new `req_b` is served normally.
